// File: rtl/csr_file_if.sv
// CSR file bus: CSR read/write port, trap/mret commit events, redirect back
// to fetch, and the state exported to the rest of the core.
interface csr_file_if;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_illegal;

    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [1:0]  wr_op;
    logic [63:0] wr_data;
    logic        wr_illegal;

    logic        trap_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_epc;
    logic [63:0] trap_tval;
    logic        mret_valid;

    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  priv;
    logic [63:0] mstatus_o;
    logic [63:0] satp_o;

    // CSR file side
    modport slave (
        input  rd_addr, wr_valid, wr_addr, wr_op, wr_data,
        input  trap_valid, trap_cause, trap_epc, trap_tval, mret_valid,
        output rd_data, rd_illegal, wr_illegal,
        output redirect_valid, redirect_pc, priv, mstatus_o, satp_o
    );

    // Core / commit-stage side
    modport master (
        output rd_addr, wr_valid, wr_addr, wr_op, wr_data,
        output trap_valid, trap_cause, trap_epc, trap_tval, mret_valid,
        input  rd_data, rd_illegal, wr_illegal,
        input  redirect_valid, redirect_pc, priv, mstatus_o, satp_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational reads, masked RW/RS/RC writes,
// trap entry and mret with a one-cycle PC redirect to fetch.
module csr_file #(
    parameter logic [63:0] HART_ID = 64'd0
) (
    input  logic       clk,
    input  logic       reset,
    csr_file_if.slave  bus
);

    localparam logic [11:0] A_SSTATUS  = 12'h100;
    localparam logic [11:0] A_SATP     = 12'h180;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MEDELEG  = 12'h302;
    localparam logic [11:0] A_MIDELEG  = 12'h303;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] A_PMPADDR0 = 12'h3B0;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [63:0] MSTATUS_MASK = 64'h0000_0000_007e_79bb;
    localparam logic [63:0] SSTATUS_MASK = 64'h8000_0003_0001_e000;
    localparam logic [63:0] MIP_MASK     = 64'h0000_0000_0000_0333;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    // mstatus field positions
    localparam int MS_MIE  = 3;
    localparam int MS_MPIE = 7;
    localparam int MS_MPP  = 11;

    typedef enum logic {IDLE, REDIR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  priv_q, priv_d;
    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mtval_q, mtval_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mip_q, mip_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] satp_q, satp_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] rpc_q, rpc_d;

    logic [64:0] rd_look;
    logic [64:0] wr_look;
    logic [63:0] wr_old;
    logic [63:0] wr_new;
    logic        wr_fire;
    logic [63:0] trap_base;

    // Shared address decode: bit 64 = implemented, [63:0] = current value.
    // Delegation and PMP registers exist but are hardwired to zero.
    function automatic logic [64:0] csr_lookup(input logic [11:0] addr);
        logic [64:0] r;
        r = {1'b1, 64'd0};
        case (addr)
            A_MSTATUS:  r[63:0] = mstatus_q;
            A_SSTATUS:  r[63:0] = mstatus_q & SSTATUS_MASK;
            A_MTVEC:    r[63:0] = mtvec_q;
            A_MEPC:     r[63:0] = mepc_q;
            A_MCAUSE:   r[63:0] = mcause_q;
            A_MTVAL:    r[63:0] = mtval_q;
            A_MIE:      r[63:0] = mie_q;
            A_MIP:      r[63:0] = mip_q;
            A_MSCRATCH: r[63:0] = mscratch_q;
            A_SATP:     r[63:0] = satp_q;
            A_MCYCLE:   r[63:0] = mcycle_q;
            A_MHARTID:  r[63:0] = HART_ID;
            A_MEDELEG, A_MIDELEG, A_PMPCFG0, A_PMPADDR0: r[63:0] = 64'd0;
            default:    r[64] = 1'b0;
        endcase
        return r;
    endfunction

    // Read port: value plus legality against the current privilege level
    always_comb begin
        rd_look        = csr_lookup(bus.rd_addr);
        bus.rd_data    = rd_look[63:0];
        bus.rd_illegal = ~rd_look[64] | (bus.rd_addr[9:8] > priv_q);
    end

    // Write operand: merge operand with the old value and flag bad targets
    always_comb begin
        wr_look = csr_lookup(bus.wr_addr);
        wr_old  = wr_look[63:0];
        case (bus.wr_op)
            2'b01:   wr_new = bus.wr_data;
            2'b10:   wr_new = wr_old | bus.wr_data;
            2'b11:   wr_new = wr_old & ~bus.wr_data;
            default: wr_new = wr_old;
        endcase
        // addr[11:10]==11 covers mhartid and every other read-only CSR
        bus.wr_illegal = ~wr_look[64] | (bus.wr_addr[11:10] == 2'b11);
    end

    // A CSR write only lands when no trap/mret claims the cycle and the
    // pipeline is not being flushed.
    assign wr_fire = (state_q == IDLE) && !bus.trap_valid && !bus.mret_valid &&
                     bus.wr_valid && (bus.wr_op != 2'b00) && !bus.wr_illegal;

    assign trap_base = {mtvec_q[63:2], 2'b00};

    // Next-state: FSM transitions, trap/mret side effects and CSR writes
    always_comb begin
        state_d    = state_q;
        priv_d     = priv_q;
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mie_d      = mie_q;
        mip_d      = mip_q;
        mscratch_d = mscratch_q;
        satp_d     = satp_q;
        mcycle_d   = mcycle_q + 64'd1;
        rpc_d      = rpc_q;

        case (state_q)
            IDLE: begin
                if (bus.trap_valid) begin
                    mepc_d                      = bus.trap_epc;
                    mcause_d                    = bus.trap_cause;
                    mtval_d                     = bus.trap_tval;
                    mstatus_d[MS_MPIE]          = mstatus_q[MS_MIE];
                    mstatus_d[MS_MIE]           = 1'b0;
                    mstatus_d[MS_MPP+1:MS_MPP]  = priv_q;
                    priv_d                      = PRIV_M;
                    // Vectored mode only applies to interrupts
                    if (mtvec_q[0] && bus.trap_cause[63])
                        rpc_d = trap_base + {56'd0, bus.trap_cause[5:0], 2'b00};
                    else
                        rpc_d = trap_base;
                    state_d = REDIR;
                end else if (bus.mret_valid) begin
                    mstatus_d[MS_MIE]           = mstatus_q[MS_MPIE];
                    mstatus_d[MS_MPIE]          = 1'b1;
                    mstatus_d[MS_MPP+1:MS_MPP]  = PRIV_U;
                    priv_d                      = mstatus_q[MS_MPP+1:MS_MPP];
                    rpc_d                       = mepc_q;
                    state_d                     = REDIR;
                end else if (wr_fire) begin
                    case (bus.wr_addr)
                        A_MSTATUS:  mstatus_d  = (mstatus_q & ~MSTATUS_MASK) | (wr_new & MSTATUS_MASK);
                        A_SSTATUS:  mstatus_d  = (mstatus_q & ~SSTATUS_MASK) | (wr_new & SSTATUS_MASK);
                        A_MTVEC:    mtvec_d    = wr_new & ~64'h2;
                        A_MEPC:     mepc_d     = {wr_new[63:2], 2'b00};
                        A_MCAUSE:   mcause_d   = wr_new;
                        A_MTVAL:    mtval_d    = wr_new;
                        A_MIE:      mie_d      = wr_new;
                        A_MIP:      mip_d      = (mip_q & ~MIP_MASK) | (wr_new & MIP_MASK);
                        A_MSCRATCH: mscratch_d = wr_new;
                        A_SATP:     satp_d     = wr_new;
                        A_MCYCLE:   mcycle_d   = wr_new;
                        default:    ;
                    endcase
                end
            end
            REDIR: begin
                // Pipeline flush cycle: all commit inputs are ignored
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register for the FSM, CSRs, privilege and redirect target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            priv_q     <= PRIV_M;
            mstatus_q  <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mie_q      <= '0;
            mip_q      <= '0;
            mscratch_q <= '0;
            satp_q     <= '0;
            mcycle_q   <= '0;
            rpc_q      <= '0;
        end else begin
            state_q    <= state_d;
            priv_q     <= priv_d;
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mscratch_q <= mscratch_d;
            satp_q     <= satp_d;
            mcycle_q   <= mcycle_d;
            rpc_q      <= rpc_d;
        end
    end

    assign bus.redirect_valid = (state_q == REDIR);
    assign bus.redirect_pc    = rpc_q;
    assign bus.priv           = priv_q;
    assign bus.mstatus_o      = mstatus_q;
    assign bus.satp_o         = satp_q;

endmodule
